// File: rtl/amm_pkg.sv
// Shared Avalon-MM definitions: default geometry, latency and the stall-phase
// encoding used by the waitrequest pattern generators.
package amm_pkg;

  localparam int unsigned AMM_DEF_DATA_WIDTH = 32;
  localparam int unsigned AMM_DEF_ADDR_WIDTH = 10;
  localparam int unsigned AMM_DEF_RD_LATENCY = 2;

  typedef enum logic {
    PH_ON  = 1'b0,
    PH_OFF = 1'b1
  } stall_phase_e;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/amm_mem_slave_if.sv
// Read and write Avalon-MM ports of the memory slave. Handshake: a request
// transfers on a rising edge where read/write is 1 and its waitrequest is 0.
interface amm_mem_slave_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned BYTE_CNT   = DATA_WIDTH / 8
) ();

  logic [ADDR_WIDTH-1:0] amm_rd_address_i;
  logic                  amm_rd_read_i;
  logic [DATA_WIDTH-1:0] amm_rd_readdata_o;
  logic                  amm_rd_readdatavalid_o;
  logic                  amm_rd_waitrequest_o;

  logic [ADDR_WIDTH-1:0] amm_wr_address_i;
  logic                  amm_wr_write_i;
  logic [DATA_WIDTH-1:0] amm_wr_writedata_i;
  logic [BYTE_CNT-1:0]   amm_wr_byteenable_i;
  logic                  amm_wr_waitrequest_o;

  modport slave (
    input  amm_rd_address_i, amm_rd_read_i,
    output amm_rd_readdata_o, amm_rd_readdatavalid_o, amm_rd_waitrequest_o,
    input  amm_wr_address_i, amm_wr_write_i, amm_wr_writedata_i, amm_wr_byteenable_i,
    output amm_wr_waitrequest_o
  );

  modport master (
    output amm_rd_address_i, amm_rd_read_i,
    input  amm_rd_readdata_o, amm_rd_readdatavalid_o, amm_rd_waitrequest_o,
    output amm_wr_address_i, amm_wr_write_i, amm_wr_writedata_i, amm_wr_byteenable_i,
    input  amm_wr_waitrequest_o
  );

endinterface

// File: rtl/amm_stall_gen.sv
// Free-running waitrequest pattern: ON cycles high, OFF cycles low, repeating.
// ON=0 keeps the stall low forever; OFF=0 (with ON>0) keeps it high forever.
module amm_stall_gen
  import amm_pkg::*;
#(
  parameter int unsigned ON  = 2,
  parameter int unsigned OFF = 2
) (
  input  logic clk_i,
  input  logic srst_i,
  output logic stall_o
);

  localparam int unsigned CW = cnt_width((ON > OFF) ? ON : OFF);
  localparam logic [CW-1:0] ON_LAST  = CW'((ON  > 0) ? ON  - 1 : 0);
  localparam logic [CW-1:0] OFF_LAST = CW'((OFF > 0) ? OFF - 1 : 0);

  stall_phase_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q <= PH_ON;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    unique case (state_q)
      PH_ON: begin
        if (cnt_q == ON_LAST) begin
          state_d = PH_OFF;
          cnt_d   = '0;
        end
      end
      PH_OFF: begin
        if (cnt_q == OFF_LAST) begin
          state_d = PH_ON;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = PH_ON;
        cnt_d   = '0;
      end
    endcase
  end

  // Reset drives the first-ON value directly so the port is stalled during reset.
  always_comb begin
    if (ON == 0)       stall_o = 1'b0;
    else if (OFF == 0) stall_o = 1'b1;
    else               stall_o = srst_i || (state_q == PH_ON);
  end

endmodule

// File: rtl/amm_mem_slave.sv
// Byte-enabled RAM behind separate Avalon-MM read and write ports, with a
// fixed-latency pipelined read path and programmable waitrequest patterns.
module amm_mem_slave
  import amm_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = AMM_DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH   = AMM_DEF_ADDR_WIDTH,
  parameter int unsigned BYTE_CNT     = DATA_WIDTH / 8,
  parameter int unsigned RD_LATENCY   = AMM_DEF_RD_LATENCY,
  parameter int unsigned RD_STALL_ON  = 0,
  parameter int unsigned RD_STALL_OFF = 1,
  parameter int unsigned WR_STALL_ON  = 2,
  parameter int unsigned WR_STALL_OFF = 2
) (
  input  logic            clk_i,
  input  logic            srst_i,
  amm_mem_slave_if.slave  amm_if
);

  logic rd_stall, wr_stall, rd_acc, wr_acc;

  amm_stall_gen #(.ON(RD_STALL_ON), .OFF(RD_STALL_OFF)) u_rd_stall (
    .clk_i(clk_i), .srst_i(srst_i), .stall_o(rd_stall)
  );

  amm_stall_gen #(.ON(WR_STALL_ON), .OFF(WR_STALL_OFF)) u_wr_stall (
    .clk_i(clk_i), .srst_i(srst_i), .stall_o(wr_stall)
  );

  assign amm_if.amm_rd_waitrequest_o = rd_stall;
  assign amm_if.amm_wr_waitrequest_o = wr_stall;
  assign rd_acc = amm_if.amm_rd_read_i  && !rd_stall && !srst_i;
  assign wr_acc = amm_if.amm_wr_write_i && !wr_stall && !srst_i;

  // Storage is deliberately not reset.
  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

  always_ff @(posedge clk_i) begin
    if (wr_acc) begin
      for (int b = 0; b < BYTE_CNT; b++) begin
        if (amm_if.amm_wr_byteenable_i[b])
          mem_q[amm_if.amm_wr_address_i][8*b +: 8] <= amm_if.amm_wr_writedata_i[8*b +: 8];
      end
    end
  end

  // Stage 0 samples the RAM before this edge's write lands, giving read-before-write.
  logic [RD_LATENCY-1:0] vld_q, vld_d;
  logic [DATA_WIDTH-1:0] dat_q [RD_LATENCY];
  logic [DATA_WIDTH-1:0] dat_d [RD_LATENCY];

  always_comb begin
    vld_d[0] = rd_acc;
    dat_d[0] = rd_acc ? mem_q[amm_if.amm_rd_address_i] : dat_q[0];
    for (int i = 1; i < RD_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      dat_d[i] = vld_q[i-1] ? dat_q[i-1] : dat_q[i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LATENCY; i++) dat_q[i] <= '0;
    end else begin
      vld_q <= vld_d;
      for (int i = 0; i < RD_LATENCY; i++) dat_q[i] <= dat_d[i];
    end
  end

  assign amm_if.amm_rd_readdatavalid_o = vld_q[RD_LATENCY-1];
  assign amm_if.amm_rd_readdata_o      = dat_q[RD_LATENCY-1];

endmodule
